// File: rtl/memory_ni_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_ni_pkg
// Description : Flit format shared by the memory-node RX and TX network
//               interfaces: type codes, FSM state codes, field positions
//               and the 10-bit nibble/column check function.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_ni_pkg;

   // Flit type carried in the two MSBs of every flit
   typedef enum logic [1:0] {
      FLIT_HEAD    = 2'b00,
      FLIT_BODY    = 2'b01,
      FLIT_ILLEGAL = 2'b10,
      FLIT_TAIL    = 2'b11
   } flitType_t;

   // Receive FSM state codes
   localparam logic [1:0] ST_W_HEAD  = 2'd0;
   localparam logic [1:0] ST_W_BODY  = 2'd1;
   localparam logic [1:0] ST_W_TAIL  = 2'd2;
   localparam logic [1:0] ST_DELIVER = 2'd3;

   // Field widths and bit positions
   localparam int FLIT_W   = 32;
   localparam int DATA_W   = 24;
   localparam int CHK_W    = 10;
   localparam int SRC_W    = 4;
   localparam int ADDR_W   = 5;
   localparam int TYPE_MSB = 31;
   localparam int TYPE_LSB = 30;
   localparam int SRC_MSB  = 8;
   localparam int SRC_LSB  = 5;
   localparam int DEST_MSB = 4;
   localparam int DEST_LSB = 0;
   localparam int DATA_MSB = 23;
   localparam int DATA_LSB = 0;
   localparam int CHK_MSB  = 9;
   localparam int CHK_LSB  = 0;

   // chk[5:0]: XNOR of each nibble; chk[9:6]: XNOR of each nibble column
   function automatic logic [CHK_W-1:0] calcChk(input logic [DATA_W-1:0] data);
      logic [CHK_W-1:0] chk;
      logic             col;
      chk = '0;
      for (int k = 0; k < 6; k++) begin
         chk[k] = ~^data[4*k +: 4];
      end
      for (int j = 0; j < 4; j++) begin
         col = 1'b1;
         for (int m = 0; m < 6; m++) begin
            col = col ^ data[j + 4*m];
         end
         chk[6+j] = col;
      end
      return chk;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_ni_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_ni_rx_if
// Description : Ejection-FIFO and memory-controller signals of the memory
//               node receive interface. ErrCnt_o exists only when
//               MEMORY_NI_RX_ERRCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_ni_rx_if;
   import memory_ni_pkg::*;

   logic              FifoEmpty_i;
   logic [FLIT_W-1:0] FifoRdData_i;
   logic              FifoRd_o;
   logic              MemValid_o;
   logic              MemReady_i;
   logic [DATA_W-1:0] MemData_o;
   logic [SRC_W-1:0]  MemSrc_o;
   logic              MemErr_o;
   logic              ProtoErr_o;

`ifdef MEMORY_NI_RX_ERRCNT_EN
   logic [15:0]       ErrCnt_o;

   modport master (
      input  FifoEmpty_i, FifoRdData_i, MemReady_i,
      output FifoRd_o, MemValid_o, MemData_o, MemSrc_o, MemErr_o, ProtoErr_o, ErrCnt_o
   );
   modport slave (
      output FifoEmpty_i, FifoRdData_i, MemReady_i,
      input  FifoRd_o, MemValid_o, MemData_o, MemSrc_o, MemErr_o, ProtoErr_o, ErrCnt_o
   );
`else
   modport master (
      input  FifoEmpty_i, FifoRdData_i, MemReady_i,
      output FifoRd_o, MemValid_o, MemData_o, MemSrc_o, MemErr_o, ProtoErr_o
   );
   modport slave (
      output FifoEmpty_i, FifoRdData_i, MemReady_i,
      input  FifoRd_o, MemValid_o, MemData_o, MemSrc_o, MemErr_o, ProtoErr_o
   );
`endif

endinterface
`default_nettype wire

// File: rtl/memory_ni_chk.sv
`default_nettype none
// ============================================================================
// Module      : memory_ni_chk
// Description : Combinational 24-bit data to 10-bit nibble/column check
//               generator, shared by the RX and TX network interfaces.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_ni_chk
   import memory_ni_pkg::*;
(
   input  wire  [DATA_W-1:0] Data_i,
   output logic [CHK_W-1:0]  Chk_o
);

   assign Chk_o = calcChk(Data_i);

endmodule
`default_nettype wire

// File: rtl/memory_ni_rx.sv
`default_nettype none
// ============================================================================
// Module      : memory_ni_rx
// Description : Memory-node receive network interface. Pops HEAD/BODY/TAIL
//               flits from a first-word-fall-through ejection FIFO, filters
//               on destination address, checks the TAIL parity and hands the
//               payload to the memory controller over valid/ready.
//               Optional error counter: define MEMORY_NI_RX_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_ni_rx
   import memory_ni_pkg::*;
#(
   parameter logic [ADDR_W-1:0] MY_ADDR = 5'd25
) (
   input  wire            clk,
   input  wire            rstn,
   memory_ni_rx_if.master bus
);

   logic [1:0]        r_state;
   logic [1:0]        w_nextState;
   flitType_t         w_type;
   logic              w_rd;
   logic              w_latchHead;
   logic              w_latchBody;
   logic              w_deliver;
   logic              w_accept;
   logic              w_protoErr;
   logic              w_parErr;
   logic [CHK_W-1:0]  w_chk;
   logic [SRC_W-1:0]  r_src;
   logic              r_drop;
   logic [DATA_W-1:0] r_data;
   logic              r_memValid;
   logic [DATA_W-1:0] r_memData;
   logic [SRC_W-1:0]  r_memSrc;
   logic              r_memErr;
   logic              r_protoErr;
   logic              w_unusedRsvd;

   assign w_type       = flitType_t'(bus.FifoRdData_i[TYPE_MSB:TYPE_LSB]);
   // Every available flit is consumed immediately except while a payload is pending
   assign w_rd         = ~bus.FifoEmpty_i & (r_state != ST_DELIVER);
   assign bus.FifoRd_o = w_rd;
   // Reserved flit bits carry no information for any flit type
   assign w_unusedRsvd = ^bus.FifoRdData_i[TYPE_LSB-1:DATA_MSB+1];

   // Check bits of the latched body, compared against the TAIL check field
   memory_ni_chk u_chk (
      .Data_i (r_data),
      .Chk_o  (w_chk)
   );
   assign w_parErr = (w_chk != bus.FifoRdData_i[CHK_MSB:CHK_LSB]);

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_W_HEAD;
      else       r_state <= w_nextState;
   end

   // Next-state decode; a HEAD anywhere mid-packet restarts the packet
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_W_HEAD: begin
            if (w_rd && w_type == FLIT_HEAD) w_nextState = ST_W_BODY;
         end
         ST_W_BODY: begin
            if (w_rd) begin
               case (w_type)
                  FLIT_BODY: w_nextState = ST_W_TAIL;
                  FLIT_HEAD: w_nextState = ST_W_BODY;
                  default:   w_nextState = ST_W_HEAD;
               endcase
            end
         end
         ST_W_TAIL: begin
            if (w_rd) begin
               case (w_type)
                  FLIT_TAIL: w_nextState = r_drop ? ST_W_HEAD : ST_DELIVER;
                  FLIT_HEAD: w_nextState = ST_W_BODY;
                  default:   w_nextState = ST_W_HEAD;
               endcase
            end
         end
         ST_DELIVER: begin
            if (r_memValid && bus.MemReady_i) w_nextState = ST_W_HEAD;
         end
         default: w_nextState = ST_W_HEAD;
      endcase
   end

   // Per-state action strobes; any flit other than the expected type is a protocol error
   always_comb begin
      w_latchHead = 1'b0;
      w_latchBody = 1'b0;
      w_deliver   = 1'b0;
      w_accept    = 1'b0;
      w_protoErr  = 1'b0;
      case (r_state)
         ST_W_HEAD: begin
            if (w_rd) begin
               w_latchHead = (w_type == FLIT_HEAD);
               w_protoErr  = (w_type != FLIT_HEAD);
            end
         end
         ST_W_BODY: begin
            if (w_rd) begin
               w_latchHead = (w_type == FLIT_HEAD);
               w_latchBody = (w_type == FLIT_BODY);
               w_protoErr  = (w_type != FLIT_BODY);
            end
         end
         ST_W_TAIL: begin
            if (w_rd) begin
               w_latchHead = (w_type == FLIT_HEAD);
               w_deliver   = (w_type == FLIT_TAIL) & ~r_drop;
               w_protoErr  = (w_type != FLIT_TAIL);
            end
         end
         ST_DELIVER: begin
            w_accept = r_memValid & bus.MemReady_i;
         end
         default: ;
      endcase
   end

   // Packet capture and registered outputs; payload holds until accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_src      <= '0;
         r_drop     <= 1'b0;
         r_data     <= '0;
         r_memValid <= 1'b0;
         r_memData  <= '0;
         r_memSrc   <= '0;
         r_memErr   <= 1'b0;
         r_protoErr <= 1'b0;
      end else begin
         r_protoErr <= w_protoErr;
         if (w_latchHead) begin
            r_src  <= bus.FifoRdData_i[SRC_MSB:SRC_LSB];
            r_drop <= (bus.FifoRdData_i[DEST_MSB:DEST_LSB] != MY_ADDR);
         end
         if (w_latchBody) begin
            r_data <= bus.FifoRdData_i[DATA_MSB:DATA_LSB];
         end
         if (w_deliver) begin
            r_memValid <= 1'b1;
            r_memData  <= r_data;
            r_memSrc   <= r_src;
            r_memErr   <= w_parErr;
         end else if (w_accept) begin
            r_memValid <= 1'b0;
         end
      end
   end

   assign bus.MemValid_o = r_memValid;
   assign bus.MemData_o  = r_memData;
   assign bus.MemSrc_o   = r_memSrc;
   assign bus.MemErr_o   = r_memErr;
   assign bus.ProtoErr_o = r_protoErr;

`ifdef MEMORY_NI_RX_ERRCNT_EN
   logic [15:0] r_errCnt;
   logic        w_errInc;

   // Delivery with bad parity and protocol errors come from different flits, so one step suffices
   assign w_errInc = (w_deliver & w_parErr) | w_protoErr;

   // Saturating error counter, updated on the same edge as MemErr_o/ProtoErr_o
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                 r_errCnt <= '0;
      else if (w_errInc && r_errCnt != 16'hFFFF) r_errCnt <= r_errCnt + 16'd1;
   end

   assign bus.ErrCnt_o = r_errCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_ni_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_ni_rx
// Description : Scoreboard bench for memory_ni_rx. The stimulus process acts
//               as the ejection FIFO and pushes expected payloads; a monitor
//               process checks deliveries, hold stability and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_ni_rx;

   typedef struct packed {
      logic [23:0] data;
      logic [3:0]  src;
      logic        err;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   memory_ni_rx_if bus();

   memory_ni_rx #(.MY_ADDR(5'd25)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   exp_t        expQ[$];
   logic [31:0] fifoQ[$];
   int          total    = 0;
   int          bad      = 0;
   int          expProto = 0;
   int          gotProto = 0;
   int          nBadChk  = 0;
   int          cntBase  = 0;
   logic        readyFix = 1'b1;
   bit          randReady = 1'b0;
   bit          gapMode   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference check: even number of ones in a nibble / column gives a 1
   function automatic logic [9:0] refChk(input logic [23:0] d);
      logic [9:0] c;
      for (int k = 0; k < 6; k++) c[k] = ($countones((d >> (4*k)) & 24'hF) % 2) == 0;
      for (int j = 0; j < 4; j++) c[6+j] = ($countones(d & (24'h111111 << j)) % 2) == 0;
      return c;
   endfunction

   function automatic logic [31:0] mkHead(input logic [3:0] s, input logic [4:0] d);
      return {2'b00, 21'($urandom), s, d};
   endfunction
   function automatic logic [31:0] mkBody(input logic [23:0] d);
      return {2'b01, 6'($urandom), d};
   endfunction
   function automatic logic [31:0] mkTail(input logic [9:0] c);
      return {2'b11, 20'($urandom), c};
   endfunction

   task automatic drive();
      bus.FifoEmpty_i  = (fifoQ.size() == 0);
      bus.FifoRdData_i = (fifoQ.size() != 0) ? fifoQ[0] : 32'h0;
   endtask

   // One clock: note whether the DUT pops, then update the FIFO model after the edge
   task automatic tick();
      logic rd;
      @(negedge clk);
      rd = rstn && bus.FifoRd_o;
      @(posedge clk);
      #1;
      if (rd && fifoQ.size() > 0) fifoQ.delete(0);
      bus.MemReady_i = randReady ? ($urandom_range(0, 3) != 0) : readyFix;
      drive();
   endtask

   task automatic pushFlit(input logic [31:0] f);
      fifoQ.push_back(f);
      drive();
      if (gapMode) repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic sendPkt(input logic [3:0] s, input logic [23:0] d, input bit flip);
      logic [9:0] c;
      c = refChk(d);
      if (flip) begin
         c = c ^ (10'd1 << $urandom_range(0, 9));
         nBadChk++;
      end
      expQ.push_back('{data: d, src: s, err: flip});
      pushFlit(mkHead(s, 5'd25));
      pushFlit(mkBody(d));
      pushFlit(mkTail(c));
   endtask

   // Random packet-level scenario; each one leaves the receiver waiting for a HEAD
   task automatic randPkt();
      int          kind;
      logic [3:0]  s;
      logic [23:0] d;
      logic [4:0]  wd;
      kind = $urandom_range(0, 7);
      s    = 4'($urandom);
      d    = 24'($urandom);
      wd   = 5'($urandom_range(0, 31));
      if (wd == 5'd25) wd = 5'd24;
      case (kind)
         0: sendPkt(s, d, 1'b0);
         1: sendPkt(s, d, 1'b1);
         2: begin
            pushFlit(mkHead(s, wd));
            pushFlit(mkBody(d));
            pushFlit(mkTail(10'($urandom)));
         end
         3: begin
            expProto++;
            pushFlit(mkHead(4'($urandom), 5'($urandom)));
            sendPkt(s, d, 1'b0);
         end
         4: begin
            expProto++;
            pushFlit({2'($urandom_range(1, 3)), 30'($urandom)});
         end
         5: begin
            expProto++;
            pushFlit(mkHead(s, 5'd25));
            pushFlit({($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, 30'($urandom)});
         end
         6: begin
            expProto++;
            pushFlit(mkHead(s, 5'd25));
            pushFlit(mkBody(d));
            pushFlit({($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 30'($urandom)});
         end
         default: begin
            expProto++;
            pushFlit(mkHead(4'($urandom), 5'($urandom)));
            pushFlit(mkBody(24'($urandom)));
            sendPkt(s, d, bit'($urandom_range(0, 1)));
         end
      endcase
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (n < 3000 && !(fifoQ.size() == 0 && expQ.size() == 0 && !bus.MemValid_o)) begin
         tick();
         n++;
      end
      if (n >= 3000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: fifo=%0d pending=%0d required=0/0", fifoQ.size(), expQ.size());
      end
      tick();
      tick();
   endtask

   // Monitor: scoreboard pop on acceptance, hold stability, no reads while pending, latency
   logic pV = 1'b0;
   logic pR = 1'b0;
   logic pTail = 1'b0;
   exp_t pOut = '0;
   exp_t e;
   always @(negedge clk) begin
      if (!rstn) begin
         pV    <= 1'b0;
         pR    <= 1'b0;
         pTail <= 1'b0;
      end else begin
         if (bus.ProtoErr_o) gotProto++;
         if (bus.MemValid_o) check("no_read_while_valid", 64'(bus.FifoRd_o), 64'(0));
         if (pV && !pR) begin
            check("hold_valid", 64'(bus.MemValid_o), 64'(1));
            check("hold_payload", 64'({bus.MemData_o, bus.MemSrc_o, bus.MemErr_o}), 64'(pOut));
         end
         if (bus.MemValid_o && !pV) check("latency_after_tail", 64'(pTail), 64'(1));
         if (bus.MemValid_o && bus.MemReady_i) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_delivery: actual data=%h src=%h required none",
                        bus.MemData_o, bus.MemSrc_o);
            end else begin
               e = expQ.pop_front();
               check("payload", 64'({bus.MemData_o, bus.MemSrc_o, bus.MemErr_o}), 64'(e));
            end
         end
         pV    <= bus.MemValid_o;
         pR    <= bus.MemReady_i;
         pOut  <= {bus.MemData_o, bus.MemSrc_o, bus.MemErr_o};
         pTail <= bus.FifoRd_o && (bus.FifoRdData_i[31:30] == 2'b11);
      end
   end

   initial begin
      bus.FifoEmpty_i  = 1'b1;
      bus.FifoRdData_i = 32'h0;
      bus.MemReady_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      check("reset_outputs", 64'({bus.MemValid_o, bus.MemData_o, bus.MemSrc_o, bus.MemErr_o,
                                  bus.ProtoErr_o, bus.FifoRd_o}), 64'(0));
`ifdef MEMORY_NI_RX_ERRCNT_EN
      check("reset_errcnt", 64'(bus.ErrCnt_o), 64'(0));
`endif

      // Good packet
      expQ.push_back('{data: 24'h000001, src: 4'd3, err: 1'b0});
      pushFlit(32'h20000079);
      pushFlit(32'h40000001);
      pushFlit(32'hC00003BE);
      drain();

      // Parity error
      nBadChk++;
      expQ.push_back('{data: 24'h000001, src: 4'd3, err: 1'b1});
      pushFlit(32'h20000079);
      pushFlit(32'h40000001);
      pushFlit(32'hC00003BF);
      drain();
`ifdef MEMORY_NI_RX_ERRCNT_EN
      check("errcnt_parity", 64'(bus.ErrCnt_o), 64'(1));
`endif

      // Wrong destination: consumed silently
      pushFlit(32'h2000007A);
      pushFlit(32'h40000001);
      pushFlit(32'hC00003BE);
      drain();
      check("proto_wrong_dest", 64'(gotProto), 64'(expProto));

      // Backpressure with a second packet queued
      readyFix = 1'b0;
      sendPkt(4'd9, 24'h123456, 1'b0);
      sendPkt(4'd2, 24'h654321, 1'b1);
      for (int i = 0; i < 50 && !bus.MemValid_o; i++) tick();
      check("bp_valid_seen", 64'(bus.MemValid_o), 64'(1));
      repeat (5) tick();
      check("bp_second_queued", 64'(fifoQ.size()), 64'(3));
      readyFix = 1'b1;
      drain();

      // Double HEAD then a complete packet
      expProto++;
      expQ.push_back('{data: 24'hABCDEF, src: 4'd5, err: 1'b0});
      pushFlit(32'h20000079);
      pushFlit(32'h000000B9);
      pushFlit(32'h40ABCDEF);
      pushFlit(32'hC0000000 | 32'(refChk(24'hABCDEF)));
      drain();

      // Lone TAIL
      expProto++;
      pushFlit(32'hC00003BE);
      drain();
      check("proto_directed", 64'(gotProto), 64'(expProto));

      // Randomized scenarios with random gaps and random ready
      randReady = 1'b1;
      gapMode   = 1'b1;
      repeat (150) randPkt();
      drain();
      check("proto_random", 64'(gotProto), 64'(expProto));
`ifdef MEMORY_NI_RX_ERRCNT_EN
      check("errcnt_random", 64'(bus.ErrCnt_o), 64'(nBadChk + expProto));
`endif

      // Reset after the BODY pop
      randReady = 1'b0;
      gapMode   = 1'b0;
      readyFix  = 1'b1;
      pushFlit(mkHead(4'd7, 5'd25));
      pushFlit(mkBody(24'h5A5A5A));
      for (int i = 0; i < 50 && fifoQ.size() != 0; i++) tick();
      tick();
      #1 rstn = 1'b0;
      #1;
      check("midreset_outputs", 64'({bus.MemValid_o, bus.MemData_o, bus.MemSrc_o, bus.MemErr_o,
                                     bus.ProtoErr_o}), 64'(0));
      cntBase = nBadChk + expProto;
`ifdef MEMORY_NI_RX_ERRCNT_EN
      check("midreset_errcnt", 64'(bus.ErrCnt_o), 64'(0));
`endif
      tick();
      tick();
      rstn = 1'b1;
      sendPkt(4'd12, 24'hC0FFEE, 1'b0);
      drain();
      check("proto_after_reset", 64'(gotProto), 64'(expProto));
`ifdef MEMORY_NI_RX_ERRCNT_EN
      check("errcnt_after_reset", 64'(bus.ErrCnt_o), 64'(nBadChk + expProto - cntBase));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_ni_rx.md
Name: memory_ni_rx

Overview:
Receive-side network interface for the memory node. It pops 3-flit packets (HEAD, BODY, TAIL) from the router's ejection FIFO and checks the destination address. It verifies the 10-bit nibble/column parity carried in TAIL and presents the 24-bit payload to the memory controller over a valid/ready handshake. It is the counterpart of the memory-side packetizer and uses the same flit format.

Parameters:
MY_ADDR, 5'd25, node address; HEAD[4:0] must equal it for the packet to be delivered.

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
FifoEmpty_i  input  1  ejection FIFO empty; FIFO is first-word-fall-through
FifoRdData_i  input  32  head-of-FIFO flit, valid when ~FifoEmpty_i
FifoRd_o  output  1  pop strobe
MemValid_o  output  1  payload valid
MemReady_i  input  1  memory accepts payload
MemData_o  output  24  payload
MemSrc_o  output  4  source ID, from HEAD[8:5]
MemErr_o  output  1  parity mismatch on the delivered payload
ProtoErr_o  output  1  one-cycle pulse on a malformed flit sequence

Behaviour:
- Flit type is [31:30]: 00 HEAD, 01 BODY, 11 TAIL, 10 illegal.
- HEAD fields: [8:5] src, [4:0] dest. BODY: [23:0] data. TAIL: [9:0] check. Reserved bits are ignored.
- Check bits:
  - chk[k] = XNOR of data[4k+3:4k], for k = 0..5.
  - chk[6+j] = XNOR of data[j], data[j+4], ..., data[j+20], for j = 0..3.
- States: W_HEAD, W_BODY, W_TAIL, DELIVER. Reset state is W_HEAD.
- All outputs reset to 0 and are registered, except FifoRd_o.
- FifoRd_o = ~FifoEmpty_i & (state != DELIVER). Every flit is consumed in one cycle; there is no read in DELIVER.
- W_HEAD:
  - HEAD popped: latch src; set drop = (dest != MY_ADDR); go to W_BODY.
  - Any other type: discard it and pulse ProtoErr_o.
- W_BODY:
  - BODY: latch data; go to W_TAIL.
  - HEAD: restart as a new packet (relatch src/drop), stay in W_BODY, pulse ProtoErr_o.
  - TAIL or 10: go to W_HEAD, pulse ProtoErr_o.
- W_TAIL:
  - TAIL with drop=0: load MemData_o, MemSrc_o, and MemErr_o = (chk != TAIL[9:0]); set MemValid_o; go to DELIVER.
  - TAIL with drop=1: go to W_HEAD with no delivery.
  - HEAD: restart as in W_BODY, pulse ProtoErr_o.
  - BODY or 10: go to W_HEAD, pulse ProtoErr_o.
- DELIVER: hold MemValid_o and all payload outputs stable until MemValid_o & MemReady_i. In that cycle, clear MemValid_o on the next edge and return to W_HEAD.
- Latency: MemValid_o rises 1 cycle after the TAIL pop. Minimum packet period is 4 cycles.
- FIFO empty mid-packet: wait in the current state; there is no timeout.
- MemReady_i while MemValid_o=0 is ignored.
- rstn low at any time: immediately return to W_HEAD with outputs 0. A partial packet is lost; the bench restarts on a flit boundary.

Optional Feature:
MEMORY_NI_RX_ERRCNT_EN
- Defined: adds output ErrCnt_o[15:0], reset 0. It increments, saturating at 16'hFFFF, on each delivered payload with MemErr_o=1 and on each ProtoErr_o pulse. When both occur in the same cycle it increments by 1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (memory_ni_pkg, also used by the TX side):
  - flit type codes FLIT_HEAD/BODY/TAIL;
  - state encodings;
  - field bit positions;
  - a function computing the 10-bit check from 24-bit data.
- One sub-module, memory_ni_chk: combinational 24->10 check generator, instantiated here and reusable by the TX.

Test Plan:
- Good packet: 0x20000079, 0x40000001, 0xC00003BE with MemReady_i=1 -> one MemValid_o pulse, MemData_o=0x000001, MemSrc_o=3, MemErr_o=0.
- Parity error: same packet with TAIL 0xC00003BF -> delivered, MemErr_o=1. With ERRCNT_EN, ErrCnt_o=1.
- Wrong destination: HEAD 0x2000007A, then BODY and TAIL -> all three popped, no MemValid_o, ProtoErr_o=0.
- Backpressure: MemReady_i=0 for 5 cycles after delivery, with a second packet queued -> FifoRd_o=0 and outputs stable throughout; second packet is delivered after acceptance.
- Malformed sequences:
  - HEAD, HEAD(src 5), BODY 0x40ABCDEF, TAIL 0xC0000000 | chk -> one ProtoErr_o pulse; delivers 0xABCDEF with src 5.
  - A lone TAIL in W_HEAD -> discarded, ProtoErr_o pulse.
- Reset mid-packet: rstn low after the BODY pop -> outputs 0; a following full packet is delivered correctly.
